// File: rtl/rs232_ser_cfg.sv
// RS-232 transmit serializer with per-frame framing control (5-8 data bits, parity, 1/2 stop bits).
// Pulls bytes from a standard (non-FWFT) FIFO and also generates line breaks on request.
module rs232_ser_cfg #(
  parameter int P_DIV_W  = 16,
  parameter int P_FIFO_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [P_DIV_W-1:0]  baud_div,
  input  logic [1:0]          cfg_data_bits,
  input  logic [1:0]          cfg_parity,
  input  logic                cfg_stop2,
  input  logic                tx_break,
  input  logic [P_FIFO_W-1:0] tx_fifo_data,
  input  logic                tx_fifo_empty,
  output logic                tx_fifo_rd_en,
  output logic                tx,
  output logic                busy,
  output logic                frame_done
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_LATCH   = 4'd2;
  localparam logic [3:0] S_START   = 4'd3;
  localparam logic [3:0] S_DATA    = 4'd4;
  localparam logic [3:0] S_PARITY  = 4'd5;
  localparam logic [3:0] S_STOP    = 4'd6;
  localparam logic [3:0] S_BREAK   = 4'd7;
  localparam logic [3:0] S_BRK_RCV = 4'd8;

  localparam logic [P_DIV_W-1:0] ONE = P_DIV_W'(1);
  localparam logic [P_DIV_W-1:0] TWO = P_DIV_W'(2);

  // Divisors below 2 would give a zero-length or single-clock bit; force 2.
  function automatic logic [P_DIV_W-1:0] clamp_div(input logic [P_DIV_W-1:0] d);
    return (d < TWO) ? TWO : d;
  endfunction

  logic [3:0]          state, state_n;
  logic [P_DIV_W-1:0]  cnt, cnt_n;
  logic [P_DIV_W-1:0]  div_r, div_n;
  logic [2:0]          bit_idx, bit_idx_n;
  logic                stop_idx, stop_idx_n;
  logic [P_FIFO_W-1:0] shift_reg, shift_n;
  logic                par_acc, par_n;
  logic [1:0]          bits_r, bits_n;
  logic [1:0]          parity_r, parity_n;
  logic                stop2_r, stop2_n;
  logic                rd_en_n, done_n, tx_n;
  logic                bit_end;
  logic                par_en;
  logic [2:0]          last_bit;

  assign bit_end  = (cnt == div_r - ONE);
  assign par_en   = (parity_r == 2'b01) || (parity_r == 2'b10);
  assign last_bit = 3'd4 + {1'b0, bits_r};

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    div_n      = div_r;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    shift_n    = shift_reg;
    par_n      = par_acc;
    bits_n     = bits_r;
    parity_n   = parity_r;
    stop2_n    = stop2_r;
    rd_en_n    = 1'b0;
    done_n     = 1'b0;
    case (state)
      S_IDLE: begin
        if (tx_break) begin
          state_n = S_BREAK;
        end else if (!tx_fifo_empty) begin
          rd_en_n = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_FETCH: state_n = S_LATCH;
      S_LATCH: begin
        // FIFO read data is valid in this cycle; freeze the whole frame's framing here.
        shift_n    = tx_fifo_data;
        div_n      = clamp_div(baud_div);
        bits_n     = cfg_data_bits;
        parity_n   = cfg_parity;
        stop2_n    = cfg_stop2;
        cnt_n      = '0;
        bit_idx_n  = '0;
        stop_idx_n = 1'b0;
        par_n      = 1'b0;
        state_n    = S_START;
      end
      S_START: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = S_DATA;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift_reg[P_FIFO_W-1:1]};
          par_n   = par_acc ^ shift_reg[0];
          if (bit_idx == last_bit) begin
            state_n = par_en ? S_PARITY : S_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = S_STOP;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (stop2_r && !stop_idx) begin
            stop_idx_n = 1'b1;
          end else begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      S_BREAK: begin
        if (!tx_break) begin
          div_n   = clamp_div(baud_div);
          cnt_n   = '0;
          state_n = S_BRK_RCV;
        end
      end
      S_BRK_RCV: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Line level is derived from the next state so tx changes on the same edge as the FSM.
    case (state_n)
      S_START, S_BREAK: tx_n = 1'b0;
      S_DATA:           tx_n = shift_n[0];
      S_PARITY:         tx_n = (parity_r == 2'b10) ? ~par_n : par_n;
      default:          tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      div_r         <= TWO;
      bit_idx       <= '0;
      stop_idx      <= 1'b0;
      shift_reg     <= '0;
      par_acc       <= 1'b0;
      bits_r        <= '0;
      parity_r      <= '0;
      stop2_r       <= 1'b0;
      tx_fifo_rd_en <= 1'b0;
      tx            <= 1'b1;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      div_r         <= div_n;
      bit_idx       <= bit_idx_n;
      stop_idx      <= stop_idx_n;
      shift_reg     <= shift_n;
      par_acc       <= par_n;
      bits_r        <= bits_n;
      parity_r      <= parity_n;
      stop2_r       <= stop2_n;
      tx_fifo_rd_en <= rd_en_n;
      tx            <= tx_n;
      busy          <= (state_n != S_IDLE);
      frame_done    <= done_n;
    end
  end

endmodule

// File: tb/tb_rs232_ser_cfg.sv
// Scoreboard bench for rs232_ser_cfg: stimulus queues expected line activity, a monitor decodes tx and compares.
module tb_rs232_ser_cfg;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] baud_div = 16'd10;
  logic [1:0]    cfg_data_bits = 2'b11;
  logic [1:0]    cfg_parity = 2'b00;
  logic          cfg_stop2 = 1'b0;
  logic          tx_break = 1'b0;
  logic [7:0]    tx_fifo_data = 8'h00;
  logic          tx_fifo_empty = 1'b1;
  logic          tx_fifo_rd_en, tx, busy, frame_done;

  rs232_ser_cfg #(.P_DIV_W(DW), .P_FIFO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .cfg_data_bits(cfg_data_bits),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .tx_break(tx_break),
    .tx_fifo_data(tx_fifo_data), .tx_fifo_empty(tx_fifo_empty),
    .tx_fifo_rd_en(tx_fifo_rd_en), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  localparam int K_FRAME = 0;
  localparam int K_BREAK = 1;
  localparam int K_ABORT = 2;

  typedef struct {
    int         kind;
    logic [11:0] bits;  // line levels, one per bit period, start bit first
    int         nb;     // frame: number of bit periods; break: expected low cycles
    int         d;      // clocks per bit
    bit         gap;    // frame follows previous one back-to-back
  } item_t;

  item_t      sb[$];
  logic [7:0] fifo_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int rd_cnt = 0;
  bit mon_busy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame built directly from the framing rules.
  function automatic item_t make_frame(input logic [7:0] b, input int dbits, input int par,
                                       input bit stop2, input int div, input bit gap);
    item_t it;
    int n, idx;
    logic p, bt;
    n = 5 + dbits;
    it.kind = K_FRAME;
    it.bits = '1;
    it.d = (div < 2) ? 2 : div;
    it.gap = gap;
    it.bits[0] = 1'b0;
    idx = 1;
    p = 1'b0;
    for (int i = 0; i < n; i++) begin
      bt = b[i];
      it.bits[idx] = bt;
      p = p ^ bt;
      idx++;
    end
    if (par == 1) begin it.bits[idx] = p; idx++; end
    else if (par == 2) begin it.bits[idx] = ~p; idx++; end
    it.bits[idx] = 1'b1; idx++;
    if (stop2) begin it.bits[idx] = 1'b1; idx++; end
    it.nb = idx;
    return it;
  endfunction

  // Upstream standard FIFO: data appears the cycle after rd_en is sampled.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_fifo_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (fifo_q.size() != 0) tx_fifo_data <= fifo_q.pop_front();
    end
    tx_fifo_empty <= (fifo_q.size() == 0);
  end

  initial begin : monitor
    item_t it;
    int errs, low, n, last_done;
    logic ptx;
    ptx = 1'b1;
    last_done = 0;
    forever begin
      @(negedge clk);
      if (tx_fifo_rd_en) check("rd_while_empty", (fifo_q.size() != 0), 1);
      if (!rst_n) begin
        ptx = 1'b1;
        continue;
      end
      if (ptx && !tx) begin
        mon_busy = 1;
        if (sb.size() == 0) begin
          check("unexpected_low", 0, 1);
        end else begin
          it = sb.pop_front();
          if (it.kind == K_FRAME) begin
            if (it.gap) check("mark_gap", cyc - last_done, 3);
            errs = 0;
            for (int k = 0; k < it.nb * it.d; k++) begin
              if (k > 0) @(negedge clk);
              if (!rst_n) break;
              if (tx !== it.bits[k / it.d] || busy !== 1'b1 || frame_done !== 1'b0) errs++;
            end
            check("frame_wave", errs, 0);
            @(negedge clk);
            check("frame_done_idle", {frame_done, busy, tx}, 3'b101);
            last_done = cyc;
          end else if (it.kind == K_BREAK) begin
            low = 0;
            errs = 0;
            while (tx === 1'b0 && rst_n && low < 5000) begin
              if (busy !== 1'b1 || tx_fifo_rd_en !== 1'b0) errs++;
              low++;
              @(negedge clk);
            end
            check("break_len", low, it.nb);
            for (int k = 0; k < it.d; k++) begin
              if (k > 0) @(negedge clk);
              if (tx !== 1'b1 || busy !== 1'b1) errs++;
            end
            check("break_recover", errs, 0);
            @(negedge clk);
            check("break_idle_busy", busy, 0);
          end else begin
            errs = 0;
            n = 0;
            while (rst_n && n < 5000) begin
              if (frame_done) errs++;
              @(negedge clk);
              n++;
            end
            check("abort_no_done", {(errs == 0), rst_n}, 2'b10);
            while (!rst_n) @(negedge clk);
          end
        end
        mon_busy = 0;
      end
      ptx = tx;
    end
  end

  task automatic send(input logic [7:0] b, input bit gap);
    sb.push_back(make_frame(b, int'(cfg_data_bits), int'(cfg_parity), cfg_stop2, int'(baud_div), gap));
    fifo_q.push_back(b);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || fifo_q.size() != 0 || busy || mon_busy) && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 4000) check("idle_timeout", 0, 1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic wait_tx_low();
    int n = 0;
    while (tx !== 1'b0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("tx_low_timeout", 0, 1);
  endtask

  task automatic set_cfg(input int db, input int par, input bit s2, input int div);
    cfg_data_bits = 2'(db);
    cfg_parity = 2'(par);
    cfg_stop2 = s2;
    baud_div = DW'(div);
  endtask

  initial begin : stim
    int rd0, w, nbytes;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_rd_en", tx_fifo_rd_en, 0);
    check("reset_done", frame_done, 0);
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    set_cfg(3, 0, 0, 10);           // 8N1, 0x55
    send(8'h55, 0);
    wait_idle();
    set_cfg(2, 1, 0, 10);           // 7E1, 0x41
    send(8'h41, 0);
    wait_idle();
    set_cfg(0, 2, 1, 6);            // 5O2, 0x13
    send(8'h13, 0);
    wait_idle();

    set_cfg(3, 0, 0, 4);            // three back-to-back frames
    rd0 = rd_cnt;
    send(8'hA7, 0);
    send(8'h3C, 1);
    send(8'hF0, 1);
    wait_idle();
    check("burst_rd_pulses", rd_cnt - rd0, 3);

    set_cfg(3, 1, 0, 5);            // break raised mid-frame
    send(8'h9E, 0);
    wait_tx_low();
    repeat (7) begin @(posedge clk); #1; end
    w = 17;
    tx_break = 1'b1;
    sb.push_back('{kind: K_BREAK, bits: '1, nb: w, d: 5, gap: 0});
    begin
      int n = 0;
      while (frame_done !== 1'b1 && n < 500) begin @(posedge clk); #1; n++; end
      if (n >= 500) check("done_timeout", 0, 1);
    end
    repeat (w) begin
      @(posedge clk); #1;
      if (fifo_q.size() == 0 && sb.size() == 1) send(8'h6B, 0);
    end
    tx_break = 1'b0;
    wait_idle();

    set_cfg(1, 2, 0, 3);            // break from idle with exact length
    tx_break = 1'b1;
    sb.push_back('{kind: K_BREAK, bits: '1, nb: 9, d: 3, gap: 0});
    repeat (9) begin @(posedge clk); #1; end
    tx_break = 1'b0;
    wait_idle();

    for (int i = 0; i < 24; i++) begin
      set_cfg($urandom_range(3, 0), $urandom_range(3, 0), 1'($urandom_range(1, 0)),
              $urandom_range(7, 0));
      nbytes = $urandom_range(3, 1);
      if (nbytes == 1) begin
        send(8'($urandom), 0);
        wait_tx_low();
        // framing inputs moving mid-frame must not disturb the frame in flight
        set_cfg($urandom_range(3, 0), $urandom_range(3, 0), 1'($urandom_range(1, 0)),
                $urandom_range(15, 0));
      end else begin
        for (int j = 0; j < nbytes; j++) send(8'($urandom), (j > 0));
      end
      wait_idle();
    end

    set_cfg(3, 0, 0, 1);            // reset mid-DATA with minimum divisor
    sb.push_back('{kind: K_ABORT, bits: '1, nb: 0, d: 2, gap: 0});
    fifo_q.push_back(8'hC3);
    wait_tx_low();
    repeat (6) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_done", frame_done, 0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    send(8'h5A, 0);
    wait_idle();

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
